axis_video_source: RTL and testbench
====================================

# axis_video_source

Single-clock AXI4-Stream video frame source producing raster-ordered pixels for `vga_controller`'s stream input. Per frame it emits V_ACTIVE lines of H_ACTIVE pixels, with TUSER on the first pixel of the frame and TLAST on the last pixel of each line. Pixel content comes from a built-in pattern generator: colour bars, ramp, checkerboard or solid colour. The block sits in the AXI clock domain, upstream of the controller's CDC FIFO, and serves as the bring-up and default video source.

## Interface
- `H_ACTIVE`, 1024: pixels per line; legal range 8..4095.
- `V_ACTIVE`, 768: lines per frame; legal range 1..4095.
- `AXIS_TDATA_WIDTH`, 16: stream data width; must be 16 when `USE_RGB888`=0 and 24 when `USE_RGB888`=1.
- `AXIS_TUSER_WIDTH`, 1: TUSER[0] marks start of frame (SOF); upper bits are always 0.
- `USE_RGB888`, 0: 0 selects RGB565 output, 1 selects RGB888 output.
- `LINE_GAP`, 0: idle cycles inserted between lines, 0..255.
- `axi_clk  in  1`: clock.
- `axi_rstn  in  1`: asynchronous active-low reset.
- `enable  in  1`: permits new frames to start.
- `frame_start  in  1`: one-cycle request to start a frame.
- `pattern_sel  in  2`: pattern select. 0 = bars, 1 = ramp, 2 = checker, 3 = solid.
- `solid_color  in  16`: RGB565 colour used by pattern 3.
- `m_axis_tdata  out  AXIS_TDATA_WIDTH`: pixel data.
- `m_axis_tuser  out  AXIS_TUSER_WIDTH`: SOF flag.
- `m_axis_tlast  out  1`: end-of-line flag.
- `m_axis_tvalid  out  1`: output data valid.
- `m_axis_tready  in  1`: downstream ready.
- `busy  out  1`: high while a frame is in progress.
- `frame_done  out  1`: one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- FSM states: IDLE, LINE, GAP.
  - IDLE → LINE when `frame_start && enable`. On this transition x=0, y=0, and `pattern_sel`/`solid_color` are captured for the whole frame.
  - LINE → (handshake on last pixel of line, not last line) → GAP if `LINE_GAP`>0, else stay in LINE with x=0, y+1.
  - GAP → LINE after exactly `LINE_GAP` cycles, with x=0, y+1.
  - LINE → (handshake on last pixel of last line) → IDLE; `frame_done` pulses on the next cycle.
- `frame_start` while busy: ignored and not queued.
- `enable` deasserted mid-frame: the current frame completes; no new frame starts.
- Output stage is a register slice, advanced only on handshake (`tvalid && tready`) or when empty.
  - With `tvalid`=1 and `tready`=0, tdata/tuser/tlast are held bit-stable.
  - `tvalid` never drops without a handshake.
- `tuser[0]`=1 only at x=0, y=0. `tlast`=1 only at x=`H_ACTIVE`-1.
- Patterns are computed in RGB565:
  - Bars: band width BW=`H_ACTIVE`/8. Band k holds x in [k·BW, (k+1)·BW); the last band absorbs the remainder. Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Ramp: R=x[9:5], G=x[9:4], B=x[9:5], with x taken modulo 1024.
  - Checker: white FFFF when x[5]^y[5]=0, else black 0000 (32×32 squares).
  - Solid: the captured `solid_color`.
- RGB888 expansion by MSB replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}. Packing: [23:16]=R, [15:8]=G, [7:0]=B.
- x and y counters are 12 bits. They never exceed `H_ACTIVE`-1 and `V_ACTIVE`-1 respectively.

## Timing
- Reset values: `tvalid`=0, `tdata`=0, `tuser`=0, `tlast`=0, `busy`=0, `frame_done`=0; FSM in IDLE. Reset takes effect asynchronously, including mid-frame. After release, no pixel is emitted until a new `frame_start`.
- Start latency: `frame_start` sampled on edge N → `tvalid`=1 with the SOF pixel after edge N+1.
- Throughput: 1 pixel per cycle while `tready`=1.
- Line gap: exactly `LINE_GAP` cycles with `tvalid`=0 between the TLAST handshake and the next line's first `tvalid`.
- Frame timing: `busy` rises with the first `tvalid` and falls together with the `frame_done` pulse. The earliest next `frame_start` is accepted one cycle after `frame_done`.
- Minimum frame duration with `tready`=1: `H_ACTIVE`·`V_ACTIVE` + (`V_ACTIVE`-1)·`LINE_GAP` cycles.

## Configuration
- `AXIS_VIDEO_SRC_STATS_EN` defined: adds two outputs.
  - `frame_count[15:0]`: increments on each `frame_done` and wraps.
  - `stall_count[31:0]`: counts `tvalid && !tready` cycles, cleared at frame start, saturates at all-ones.
  - Both counters reset to 0.
- `AXIS_VIDEO_SRC_STATS_EN` undefined: these ports and counters do not exist. Stream behaviour is identical in both cases.

## Structure
- `vga_pkg` holds:
  - pattern enum `video_pattern_e` (BARS, RAMP, CHECKER, SOLID);
  - the eight RGB565 bar colour constants;
  - function `rgb565_to_888`.
- Sub-module `video_pattern_gen`: combinational mapping from (x, y, pattern, solid_color) to RGB565. The top level holds the FSM, counters and output register.

## Test plan
- `H_ACTIVE`=16, `V_ACTIVE`=4, `tready`=1, pattern 0, one `frame_start` → 64 beats.
  - tuser only on beat 0; tlast on beats 15, 31, 47, 63.
  - Beats 0–1 = FFFF, beats 14–15 = 0000.
  - `frame_done` pulses once.
- Random `tready` at 30% duty, pattern 3 with `solid_color`=F800 → every beat is F800 and the sequence is unchanged. Payload is stable across every stall cycle.
- `LINE_GAP`=3 → exactly 3 `tvalid`=0 cycles after each TLAST except the last.
- `frame_start` pulsed mid-frame, and `pattern_sel` changed mid-frame → no restart, no pattern change, `frame_done` pulses once.
- `axi_rstn` asserted at beat 20 → `tvalid`=0 immediately. After release and a new `frame_start`, the first beat has tuser=1 and x=0.
- `USE_RGB888`=1, pattern 3 with `solid_color`=07E0 → tdata=00FF00.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared types, RGB565 bar colours and the RGB565->RGB888 helper
//            used by the video source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

   typedef enum logic [1:0] {
      BARS    = 2'd0,
      RAMP    = 2'd1,
      CHECKER = 2'd2,
      SOLID   = 2'd3
   } video_pattern_e;

   localparam logic [15:0] c_bar_white   = 16'hFFFF;
   localparam logic [15:0] c_bar_yellow  = 16'hFFE0;
   localparam logic [15:0] c_bar_cyan    = 16'h07FF;
   localparam logic [15:0] c_bar_green   = 16'h07E0;
   localparam logic [15:0] c_bar_magenta = 16'hF81F;
   localparam logic [15:0] c_bar_red     = 16'hF800;
   localparam logic [15:0] c_bar_blue    = 16'h001F;
   localparam logic [15:0] c_bar_black   = 16'h0000;

   // MSB replication keeps full-scale 5/6-bit values at full-scale 8-bit.
   function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
      return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/video_pattern_gen.sv
// ============================================================================
// Module   : video_pattern_gen
// Purpose  : Combinational RGB565 test-pattern generator (bars, ramp,
//            checkerboard, solid) addressed by pixel coordinates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_pattern_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = 1024
) (
   input  logic [11:0]    i_x,
   input  logic [11:0]    i_y,
   input  video_pattern_e i_pattern,
   input  logic [15:0]    i_solid_color,
   output logic [15:0]    o_rgb565
);

   localparam int c_band_w = H_ACTIVE / 8;

   logic [2:0]  w_band;
   logic [15:0] w_bar_color;
   logic        w_checker_white;

   // Threshold compare instead of division; band 7 soaks up the remainder.
   always_comb begin
      w_band = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (i_x >= 12'(k * c_band_w)) begin
            w_band = 3'(k);
         end
      end
   end

   always_comb begin
      case (w_band)
         3'd0:    w_bar_color = c_bar_white;
         3'd1:    w_bar_color = c_bar_yellow;
         3'd2:    w_bar_color = c_bar_cyan;
         3'd3:    w_bar_color = c_bar_green;
         3'd4:    w_bar_color = c_bar_magenta;
         3'd5:    w_bar_color = c_bar_red;
         3'd6:    w_bar_color = c_bar_blue;
         default: w_bar_color = c_bar_black;
      endcase
   end

   assign w_checker_white = (((i_x ^ i_y) & 12'h020) == 12'h000);

   always_comb begin
      case (i_pattern)
         BARS:    o_rgb565 = w_bar_color;
         RAMP:    o_rgb565 = {i_x[9:5], i_x[9:4], i_x[9:5]};
         CHECKER: o_rgb565 = w_checker_white ? 16'hFFFF : 16'h0000;
         SOLID:   o_rgb565 = i_solid_color;
         default: o_rgb565 = 16'h0000;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/axis_video_source.sv
// ============================================================================
// Module   : axis_video_source
// Purpose  : AXI4-Stream raster video source with built-in test patterns,
//            register-slice output and optional inter-line gap.
//            Define AXIS_VIDEO_SRC_STATS_EN to add frame/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_video_source
   import vga_pkg::*;
#(
   parameter int H_ACTIVE         = 1024,
   parameter int V_ACTIVE         = 768,
   parameter int AXIS_TDATA_WIDTH = 16,
   parameter int AXIS_TUSER_WIDTH = 1,
   parameter int USE_RGB888       = 0,
   parameter int LINE_GAP         = 0
) (
   input  logic                        axi_clk,
   input  logic                        axi_rstn,
   input  logic                        enable,
   input  logic                        frame_start,
   input  logic [1:0]                  pattern_sel,
   input  logic [15:0]                 solid_color,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        busy,
   output logic                        frame_done
`ifdef AXIS_VIDEO_SRC_STATS_EN
   ,
   output logic [15:0]                 frame_count,
   output logic [31:0]                 stall_count
`endif
);

   localparam logic [1:0]  c_st_idle  = 2'd0;
   localparam logic [1:0]  c_st_line  = 2'd1;
   localparam logic [1:0]  c_st_gap   = 2'd2;
   localparam logic [11:0] c_x_last   = 12'(H_ACTIVE - 1);
   localparam logic [11:0] c_y_last   = 12'(V_ACTIVE - 1);
   localparam logic [7:0]  c_gap_init = 8'(LINE_GAP - 1);
   localparam bit          c_has_gap  = (LINE_GAP > 0);

   logic [1:0]                  r_state;
   logic [1:0]                  w_next_state;
   logic [11:0]                 r_x;
   logic [11:0]                 r_y;
   logic [7:0]                  r_gap_cnt;
   video_pattern_e              r_pattern;
   logic [15:0]                 r_solid;
   logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
   logic [AXIS_TUSER_WIDTH-1:0] r_tuser;
   logic                        r_tlast;
   logic                        r_tvalid;
   logic                        r_busy;
   logic                        r_frame_done;

   logic                        w_hs;
   logic                        w_start;
   logic                        w_load;
   logic                        w_line_end;
   logic                        w_frame_end;
   logic [11:0]                 w_nx_x;
   logic [11:0]                 w_nx_y;
   logic [11:0]                 w_ld_x;
   logic [11:0]                 w_ld_y;
   logic [15:0]                 w_pix565;
   logic [AXIS_TDATA_WIDTH-1:0] w_pix_out;
   logic [AXIS_TUSER_WIDTH-1:0] w_tuser_nxt;

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: if (w_start) w_next_state = c_st_line;
         c_st_line: begin
            if (w_line_end) begin
               if (r_y == c_y_last) begin
                  w_next_state = c_st_idle;
               end else if (c_has_gap) begin
                  w_next_state = c_st_gap;
               end
            end
         end
         c_st_gap:  if (r_gap_cnt == 8'd0) w_next_state = c_st_line;
         default:   w_next_state = c_st_idle;
      endcase
   end

   // The output register holds pixel (r_x, r_y); w_ld_* is the pixel to load next.
   always_comb begin
      w_hs        = r_tvalid && m_axis_tready;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_line_end  = 1'b0;
      w_frame_end = 1'b0;
      if (r_x == c_x_last) begin
         w_nx_x = 12'd0;
         w_nx_y = r_y + 12'd1;
      end else begin
         w_nx_x = r_x + 12'd1;
         w_nx_y = r_y;
      end
      w_ld_x = w_nx_x;
      w_ld_y = w_nx_y;
      case (r_state)
         c_st_idle: w_start = frame_start && enable && !r_frame_done;
         c_st_line: begin
            w_line_end  = w_hs && r_tlast;
            w_frame_end = w_line_end && (r_y == c_y_last);
            if (!r_tvalid) begin
               w_load = 1'b1;
               w_ld_x = r_x;
               w_ld_y = r_y;
            end else if (w_hs && !r_tlast) begin
               w_load = 1'b1;
            end else if (w_line_end && !w_frame_end && !c_has_gap) begin
               w_load = 1'b1;
            end
         end
         c_st_gap:  w_load = (r_gap_cnt == 8'd0);
         default:   w_load = 1'b0;
      endcase
   end

   always_comb begin
      w_tuser_nxt    = '0;
      w_tuser_nxt[0] = (w_ld_x == 12'd0) && (w_ld_y == 12'd0);
   end

   video_pattern_gen #(
      .H_ACTIVE (H_ACTIVE)
   ) u_pattern (
      .i_x           (w_ld_x),
      .i_y           (w_ld_y),
      .i_pattern     (r_pattern),
      .i_solid_color (r_solid),
      .o_rgb565      (w_pix565)
   );

   generate
      if (USE_RGB888 != 0) begin : g_rgb888
         assign w_pix_out = rgb565_to_888(w_pix565);
      end else begin : g_rgb565
         assign w_pix_out = w_pix565;
      end
   endgenerate

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         r_x          <= 12'd0;
         r_y          <= 12'd0;
         r_gap_cnt    <= 8'd0;
         r_pattern    <= BARS;
         r_solid      <= 16'd0;
         r_tdata      <= '0;
         r_tuser      <= '0;
         r_tlast      <= 1'b0;
         r_tvalid     <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         // Pattern and colour are frozen for the whole frame.
         if (w_start) begin
            r_x       <= 12'd0;
            r_y       <= 12'd0;
            r_pattern <= video_pattern_e'(pattern_sel);
            r_solid   <= solid_color;
         end else if (w_load) begin
            r_x <= w_ld_x;
            r_y <= w_ld_y;
         end

         if (w_line_end) begin
            r_gap_cnt <= c_gap_init;
         end else if ((r_state == c_st_gap) && (r_gap_cnt != 8'd0)) begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
         end

         if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_pix_out;
            r_tuser  <= w_tuser_nxt;
            r_tlast  <= (w_ld_x == c_x_last);
         end else if (w_hs) begin
            r_tvalid <= 1'b0;
         end

         if (w_load) begin
            r_busy <= 1'b1;
         end else if (w_frame_end) begin
            r_busy <= 1'b0;
         end

         r_frame_done <= w_frame_end;
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tuser  = r_tuser;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tvalid = r_tvalid;
   assign busy          = r_busy;
   assign frame_done    = r_frame_done;

`ifdef AXIS_VIDEO_SRC_STATS_EN
   logic [15:0] r_frame_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         r_frame_count <= 16'd0;
         r_stall_count <= 32'd0;
      end else begin
         if (r_frame_done) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
         if (w_start) begin
            r_stall_count <= 32'd0;
         end else if (r_tvalid && !m_axis_tready && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end

   assign frame_count = r_frame_count;
   assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_video_source.sv
// ============================================================================
// Module   : tb_axis_video_source
// Purpose  : Self-checking bench for axis_video_source with a coordinate-based
//            pattern reference model and randomized downstream back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_video_source;

   localparam int HA = 16, VA = 4;
   localparam int HB = 80, VB = 3, GAPB = 3;
   localparam int HC = 16, VC = 2;
   localparam logic [15:0] BAR_TAB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // DUT A: 16x4, RGB565, no gap
   logic a_rstn, a_enable, a_frame_start, a_tlast, a_tvalid, a_tready, a_busy, a_frame_done;
   logic [1:0]  a_pattern_sel;
   logic [15:0] a_solid, a_tdata;
   logic [0:0]  a_tuser;
   // DUT B: 80x3, RGB565, gap of 3
   logic b_rstn, b_enable, b_frame_start, b_tlast, b_tvalid, b_tready, b_busy, b_frame_done;
   logic [1:0]  b_pattern_sel;
   logic [15:0] b_solid, b_tdata;
   logic [0:0]  b_tuser;
   // DUT C: 16x2, RGB888
   logic c_enable, c_frame_start, c_tlast, c_tvalid, c_tready, c_busy, c_frame_done;
   logic [1:0]  c_pattern_sel;
   logic [15:0] c_solid;
   logic [23:0] c_tdata;
   logic [0:0]  c_tuser;
`ifdef AXIS_VIDEO_SRC_STATS_EN
   logic [15:0] a_fc, b_fc, c_fc;
   logic [31:0] a_sc, b_sc, c_sc;
`endif

   axis_video_source #(.H_ACTIVE(HA), .V_ACTIVE(VA), .AXIS_TDATA_WIDTH(16), .AXIS_TUSER_WIDTH(1),
                       .USE_RGB888(0), .LINE_GAP(0)) dut_a (
      .axi_clk(clk), .axi_rstn(a_rstn), .enable(a_enable), .frame_start(a_frame_start),
      .pattern_sel(a_pattern_sel), .solid_color(a_solid), .m_axis_tdata(a_tdata),
      .m_axis_tuser(a_tuser), .m_axis_tlast(a_tlast), .m_axis_tvalid(a_tvalid),
      .m_axis_tready(a_tready), .busy(a_busy), .frame_done(a_frame_done)
`ifdef AXIS_VIDEO_SRC_STATS_EN
      , .frame_count(a_fc), .stall_count(a_sc)
`endif
   );

   axis_video_source #(.H_ACTIVE(HB), .V_ACTIVE(VB), .AXIS_TDATA_WIDTH(16), .AXIS_TUSER_WIDTH(1),
                       .USE_RGB888(0), .LINE_GAP(GAPB)) dut_b (
      .axi_clk(clk), .axi_rstn(b_rstn), .enable(b_enable), .frame_start(b_frame_start),
      .pattern_sel(b_pattern_sel), .solid_color(b_solid), .m_axis_tdata(b_tdata),
      .m_axis_tuser(b_tuser), .m_axis_tlast(b_tlast), .m_axis_tvalid(b_tvalid),
      .m_axis_tready(b_tready), .busy(b_busy), .frame_done(b_frame_done)
`ifdef AXIS_VIDEO_SRC_STATS_EN
      , .frame_count(b_fc), .stall_count(b_sc)
`endif
   );

   axis_video_source #(.H_ACTIVE(HC), .V_ACTIVE(VC), .AXIS_TDATA_WIDTH(24), .AXIS_TUSER_WIDTH(1),
                       .USE_RGB888(1), .LINE_GAP(0)) dut_c (
      .axi_clk(clk), .axi_rstn(b_rstn), .enable(c_enable), .frame_start(c_frame_start),
      .pattern_sel(c_pattern_sel), .solid_color(c_solid), .m_axis_tdata(c_tdata),
      .m_axis_tuser(c_tuser), .m_axis_tlast(c_tlast), .m_axis_tvalid(c_tvalid),
      .m_axis_tready(c_tready), .busy(c_busy), .frame_done(c_frame_done)
`ifdef AXIS_VIDEO_SRC_STATS_EN
      , .frame_count(c_fc), .stall_count(c_sc)
`endif
   );

   // Reference pixel straight from the pattern definitions.
   function automatic logic [15:0] model_pix(int x, int y, int pat, logic [15:0] solid, int h);
      int band, r, g;
      case (pat)
         0: begin
            band = x / (h / 8);
            if (band > 7) band = 7;
            return BAR_TAB[band];
         end
         1: begin
            r = (x % 1024) / 32;
            g = (x % 1024) / 16;
            return 16'((r << 11) | (g << 5) | r);
         end
         2: return ((((x / 32) + (y / 32)) % 2) == 0) ? 16'hFFFF : 16'h0000;
         default: return solid;
      endcase
   endfunction

   function automatic logic [23:0] model_888(logic [15:0] p);
      int r5, g6, b5, r8, g8, b8;
      r5 = int'(p) / 2048;
      g6 = (int'(p) / 32) % 64;
      b5 = int'(p) % 32;
      r8 = (r5 * 8) + (r5 / 4);
      g8 = (g6 * 4) + (g6 / 16);
      b8 = (b5 * 8) + (b5 / 4);
      return 24'((r8 * 65536) + (g8 * 256) + b8);
   endfunction

   // Frame capture for DUT A (records only, no judging)
   logic [15:0] q_data [$];
   bit          q_user [$];
   bit          q_last [$];
   int first_valid_cyc, done_cyc, n_done, n_unstable;
   bit busy_at_first, busy_at_done, timed_out;

   task automatic collect_a(input int duty, input int inject_at, input logic [1:0] inj_pat,
                            input int drop_en_at, input int max_cyc);
      logic        prev_stall, pu, pl;
      logic [15:0] pd;
      q_data.delete(); q_user.delete(); q_last.delete();
      first_valid_cyc = -1; done_cyc = -1; n_done = 0; n_unstable = 0;
      busy_at_first = 0; busy_at_done = 1; prev_stall = 0; pd = 0; pu = 0; pl = 0;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         @(posedge clk); #1;
         a_frame_start = 1'b0;
         a_tready = ($urandom_range(0, 99) < duty);
         @(negedge clk);
         if (prev_stall && (a_tvalid !== 1'b1 || a_tdata !== pd || a_tuser[0] !== pu || a_tlast !== pl))
            n_unstable++;
         if (a_tvalid && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
            busy_at_first = a_busy;
         end
         if (a_frame_done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               busy_at_done = a_busy;
            end
         end
         if (a_tvalid && a_tready) begin
            q_data.push_back(a_tdata);
            q_user.push_back(a_tuser[0]);
            q_last.push_back(a_tlast);
            if (q_data.size() == inject_at) begin
               a_frame_start = 1'b1;
               a_pattern_sel = inj_pat;
               a_solid = ~a_solid;
            end
            if (q_data.size() == drop_en_at) a_enable = 1'b0;
         end
         prev_stall = a_tvalid && !a_tready;
         pd = a_tdata; pu = a_tuser[0]; pl = a_tlast;
         if (done_cyc >= 0 && cyc >= done_cyc + 10) break;
      end
      timed_out = (done_cyc < 0);
   endtask

   task automatic test_reset();
      bit seen;
      @(negedge clk);
      n_checks++; if (a_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", a_tvalid); end
      n_checks++; if (a_tdata !== 16'h0) begin n_fail++; $display("FAIL reset_tdata: got %h expected 0000", a_tdata); end
      n_checks++; if (a_tuser !== 1'b0) begin n_fail++; $display("FAIL reset_tuser: got %b expected 0", a_tuser); end
      n_checks++; if (a_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", a_tlast); end
      n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
      n_checks++; if (a_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", a_frame_done); end
      a_rstn = 1'b1; b_rstn = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (a_tvalid !== 1'b0 || b_tvalid !== 1'b0 || c_tvalid !== 1'b0) seen = 1;
      end
      n_checks++; if (seen) begin n_fail++; $display("FAIL idle_after_reset: got tvalid=1 expected no beats"); end
   endtask

   task automatic test_bars();
      int ntu;
      a_pattern_sel = 2'd0; a_solid = 16'h1357;
      @(negedge clk); a_frame_start = 1'b1;
      collect_a(100, -1, 2'd0, -1, 500);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL bars_timeout: got no frame_done expected one"); end
      n_checks++; if (q_data.size() != HA * VA) begin n_fail++; $display("FAIL bars_count: got %0d expected %0d", q_data.size(), HA * VA); end
      n_checks++; if (first_valid_cyc != 1) begin n_fail++; $display("FAIL start_latency: got %0d expected 1", first_valid_cyc); end
      n_checks++; if (done_cyc != first_valid_cyc + HA * VA) begin n_fail++; $display("FAIL frame_duration: got %0d expected %0d", done_cyc - first_valid_cyc, HA * VA); end
      n_checks++; if (busy_at_first !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b expected 1", busy_at_first); end
      n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b expected 0", busy_at_done); end
      n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL bars_done_pulses: got %0d expected 1", n_done); end
      n_checks++; if (q_data.size() < 16 || q_data[0] !== 16'hFFFF || q_data[1] !== 16'hFFFF ||
                      q_data[14] !== 16'h0000 || q_data[15] !== 16'h0000) begin
         n_fail++; $display("FAIL bars_edges: got beats0/1/14/15 wrong expected FFFF FFFF 0000 0000");
      end
      ntu = 0;
      for (int i = 0; i < q_data.size() && i < HA * VA; i++) begin
         n_checks++;
         if (q_data[i] !== model_pix(i % HA, i / HA, 0, 16'h1357, HA) || q_user[i] !== (i == 0) ||
             q_last[i] !== ((i % HA) == HA - 1)) begin
            n_fail++;
            $display("FAIL bars_beat %0d: got data=%h user=%b last=%b expected data=%h user=%b last=%b",
                     i, q_data[i], q_user[i], q_last[i], model_pix(i % HA, i / HA, 0, 16'h1357, HA),
                     (i == 0), ((i % HA) == HA - 1));
         end
      end
   endtask

   task automatic test_random_ready();
      logic [15:0] sc;
      for (int pat = 0; pat < 4; pat++) begin
         sc = (pat == 3) ? 16'hF800 : 16'($urandom);
         a_pattern_sel = 2'(pat); a_solid = sc;
         @(negedge clk); a_frame_start = 1'b1;
         collect_a(30, -1, 2'd0, -1, 3000);
         n_checks++; if (timed_out || q_data.size() != HA * VA) begin n_fail++; $display("FAIL rr_count pat %0d: got %0d expected %0d", pat, q_data.size(), HA * VA); end
         n_checks++; if (n_unstable != 0) begin n_fail++; $display("FAIL rr_stall_stable pat %0d: got %0d unstable expected 0", pat, n_unstable); end
         n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL rr_done pat %0d: got %0d expected 1", pat, n_done); end
         for (int i = 0; i < q_data.size() && i < HA * VA; i++) begin
            n_checks++;
            if (q_data[i] !== model_pix(i % HA, i / HA, pat, sc, HA) || q_user[i] !== (i == 0) ||
                q_last[i] !== ((i % HA) == HA - 1)) begin
               n_fail++;
               $display("FAIL rr_beat pat %0d beat %0d: got %h expected %h", pat, i, q_data[i],
                        model_pix(i % HA, i / HA, pat, sc, HA));
            end
         end
      end
   endtask

   task automatic test_midframe_ignore();
      int ntu, nbad;
      bit seen;
      a_pattern_sel = 2'd3; a_solid = 16'h1234; a_enable = 1'b1;
      @(negedge clk); a_frame_start = 1'b1;
      collect_a(70, 10, 2'd0, 30, 2000);
      ntu = 0; nbad = 0;
      foreach (q_data[i]) begin
         if (q_user[i]) ntu++;
         if (q_data[i] !== 16'h1234) nbad++;
      end
      n_checks++; if (q_data.size() != HA * VA) begin n_fail++; $display("FAIL mid_count: got %0d expected %0d", q_data.size(), HA * VA); end
      n_checks++; if (nbad != 0) begin n_fail++; $display("FAIL mid_pattern: got %0d beats changed expected 0", nbad); end
      n_checks++; if (ntu != 1) begin n_fail++; $display("FAIL mid_restart: got %0d sof beats expected 1", ntu); end
      n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL mid_done: got %0d expected 1", n_done); end
      // enable is now low: a start request must be refused
      @(negedge clk); a_frame_start = 1'b1;
      @(posedge clk); #1; a_frame_start = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (a_tvalid || a_busy) seen = 1;
      end
      n_checks++; if (seen) begin n_fail++; $display("FAIL enable_low_start: got frame started expected none"); end
      a_enable = 1'b1;
   endtask

   task automatic test_line_gap();
      int pat, nbeats, gap_run, first_v, done_c;
      int gaps[$];
      logic [15:0] ex;
      pat = $urandom_range(0, 3);
      b_pattern_sel = 2'(pat); b_solid = 16'($urandom); b_tready = 1'b1;
      @(negedge clk); b_frame_start = 1'b1;
      nbeats = 0; gap_run = -1; first_v = -1; done_c = -1;
      for (int cyc = 0; cyc < 1000 && done_c < 0; cyc++) begin
         @(posedge clk); #1; b_frame_start = 1'b0;
         @(negedge clk);
         if (b_frame_done) done_c = cyc;
         else if (b_tvalid) begin
            if (first_v < 0) first_v = cyc;
            if (gap_run >= 0) gaps.push_back(gap_run);
            ex = model_pix(nbeats % HB, nbeats / HB, pat, b_solid, HB);
            n_checks++;
            if (b_tdata !== ex || b_tlast !== ((nbeats % HB) == HB - 1)) begin
               n_fail++;
               $display("FAIL gap_beat pat %0d beat %0d: got %h/%b expected %h/%b", pat, nbeats,
                        b_tdata, b_tlast, ex, ((nbeats % HB) == HB - 1));
            end
            gap_run = b_tlast ? 0 : -1;
            nbeats++;
         end else if (gap_run >= 0) gap_run++;
      end
      n_checks++; if (done_c < 0) begin n_fail++; $display("FAIL gap_timeout: got no frame_done expected one"); end
      n_checks++; if (nbeats != HB * VB) begin n_fail++; $display("FAIL gap_count: got %0d expected %0d", nbeats, HB * VB); end
      n_checks++; if (gaps.size() != VB - 1) begin n_fail++; $display("FAIL gap_num: got %0d expected %0d", gaps.size(), VB - 1); end
      foreach (gaps[i]) begin
         n_checks++; if (gaps[i] != GAPB) begin n_fail++; $display("FAIL gap_len %0d: got %0d expected %0d", i, gaps[i], GAPB); end
      end
      n_checks++;
      if (done_c - first_v != HB * VB + (VB - 1) * GAPB) begin
         n_fail++; $display("FAIL gap_frame_time: got %0d expected %0d", done_c - first_v, HB * VB + (VB - 1) * GAPB);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int seen;
      bit any;
      a_pattern_sel = 2'd0; a_tready = 1'b1; a_enable = 1'b1;
      @(negedge clk); a_frame_start = 1'b1;
      seen = 0;
      for (int cyc = 0; cyc < 200 && seen <= 20; cyc++) begin
         @(posedge clk); #1; a_frame_start = 1'b0;
         @(negedge clk);
         if (a_tvalid) seen++;
      end
      a_rstn = 1'b0;
      #1;
      n_checks++; if (a_tvalid !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset: got tvalid=%b busy=%b expected 0 0", a_tvalid, a_busy); end
      repeat (2) @(negedge clk);
      a_rstn = 1'b1;
      any = 0;
      repeat (5) begin
         @(negedge clk);
         if (a_tvalid) any = 1;
      end
      n_checks++; if (any) begin n_fail++; $display("FAIL post_reset_idle: got tvalid=1 expected 0"); end
      @(negedge clk); a_frame_start = 1'b1;
      collect_a(100, -1, 2'd0, -1, 500);
      n_checks++;
      if (q_data.size() != HA * VA || q_user[0] !== 1'b1 || q_data[0] !== 16'hFFFF || n_done != 1) begin
         n_fail++; $display("FAIL restart_after_reset: got %0d beats first user=%b data=%h expected 64 1 FFFF",
                            q_data.size(), (q_data.size() > 0) ? q_user[0] : 1'b0,
                            (q_data.size() > 0) ? q_data[0] : 16'hxxxx);
      end
   endtask

   task automatic test_rgb888();
      int pats[3] = '{3, 0, 1};
      int nbeats, done_c;
      logic [23:0] ex;
      c_tready = 1'b1;
      foreach (pats[p]) begin
         c_pattern_sel = 2'(pats[p]); c_solid = 16'h07E0;
         @(negedge clk); c_frame_start = 1'b1;
         nbeats = 0; done_c = -1;
         for (int cyc = 0; cyc < 500 && done_c < 0; cyc++) begin
            @(posedge clk); #1; c_frame_start = 1'b0;
            @(negedge clk);
            if (c_frame_done) done_c = cyc;
            else if (c_tvalid) begin
               ex = (pats[p] == 3) ? 24'h00FF00 : model_888(model_pix(nbeats % HC, nbeats / HC, pats[p], 16'h07E0, HC));
               n_checks++;
               if (c_tdata !== ex || c_tuser[0] !== (nbeats == 0)) begin
                  n_fail++; $display("FAIL rgb888 pat %0d beat %0d: got %h expected %h", pats[p], nbeats, c_tdata, ex);
               end
               nbeats++;
            end
         end
         n_checks++; if (done_c < 0 || nbeats != HC * VC) begin n_fail++; $display("FAIL rgb888_count pat %0d: got %0d expected %0d", pats[p], nbeats, HC * VC); end
         repeat (3) @(posedge clk);
      end
   endtask

   initial begin
      a_rstn = 1'b0; b_rstn = 1'b0;
      a_enable = 1'b1; a_frame_start = 1'b0; a_pattern_sel = 2'd0; a_solid = 16'h0; a_tready = 1'b1;
      b_enable = 1'b1; b_frame_start = 1'b0; b_pattern_sel = 2'd0; b_solid = 16'h0; b_tready = 1'b1;
      c_enable = 1'b1; c_frame_start = 1'b0; c_pattern_sel = 2'd0; c_solid = 16'h0; c_tready = 1'b1;
      repeat (3) @(posedge clk);
      test_reset();
      test_bars();
      test_random_ready();
      test_midframe_ignore();
      test_line_gap();
      test_reset_mid_frame();
      test_rgb888();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
